// File: rtl/emu_host_sequencer.sv
// emu_host_sequencer: host-side driver for the emulator top.
// Assembles host stream words into instruction and input vectors, issues them to the
// emulator, buffers returned output vectors in a FIFO and serializes them to the host.
// Ports:
//   clock, reset_n                      clock and asynchronous active-low reset
//   cfg_num_insns/cycles/host_steps     run configuration, sampled on start
//   cfg_used_procs                      sampled on start, driven on emu_used_procs
//   start, busy, done                   control / status (done is a 1-cycle pulse)
//   h_in_*                              host -> block word stream
//   h_out_*                             block -> host word stream
//   emu_host_steps, emu_used_procs      registered configuration to the emulator
//   insns_*, io_i_*                     instruction and input-vector ports to the emulator
//   io_o_*                              output vectors from the emulator
// Optional: define EMU_SEQ_STALL_CNT_EN to add the 32-bit perf_stall counter output.
module emu_host_sequencer #(
    parameter int unsigned LANE_W      = 16,
    parameter int unsigned INSN_LANES  = 2,
    parameter int unsigned IO_LANES    = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned PROC_W      = 3,
    parameter int unsigned OFIFO_DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [CNT_W-1:0]             cfg_num_insns,
    input  logic [CNT_W-1:0]             cfg_num_cycles,
    input  logic [CNT_W-1:0]             cfg_host_steps,
    input  logic [PROC_W-1:0]            cfg_used_procs,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic                         h_in_valid,
    output logic                         h_in_ready,
    input  logic [LANE_W-1:0]            h_in_data,
    output logic                         h_out_valid,
    input  logic                         h_out_ready,
    output logic [LANE_W-1:0]            h_out_data,
    output logic [CNT_W-1:0]             emu_host_steps,
    output logic [PROC_W-1:0]            emu_used_procs,
    output logic                         insns_valid,
    input  logic                         insns_ready,
    output logic [INSN_LANES*LANE_W-1:0] insns_bits,
    output logic                         io_i_valid,
    input  logic                         io_i_ready,
    output logic [IO_LANES*LANE_W-1:0]   io_i_bits,
    input  logic                         io_o_valid,
    output logic                         io_o_ready,
    input  logic [IO_LANES*LANE_W-1:0]   io_o_bits
`ifdef EMU_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]                  perf_stall
`endif
);

    localparam int unsigned INSN_W  = INSN_LANES * LANE_W;
    localparam int unsigned IO_W    = IO_LANES * LANE_W;
    localparam int unsigned PTR_W   = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
    localparam int unsigned FCNT_W  = PTR_W + 1;
    localparam int unsigned ILANE_W = (INSN_LANES > 1) ? $clog2(INSN_LANES) : 1;
    localparam int unsigned OLANE_W = (IO_LANES > 1) ? $clog2(IO_LANES) : 1;
    localparam int unsigned OCC_W   = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     num_insns_q, num_cycles_q, host_steps_q;
    logic [PROC_W-1:0]    used_procs_q;
    logic [CNT_W-1:0]     insn_cnt_q, issued_q, received_q;
    logic [ILANE_W-1:0]   insn_lane_q;
    logic [INSN_W-1:0]    insn_bits_q;
    logic                 insns_valid_q;
    logic [OLANE_W-1:0]   in_lane_q;
    logic [IO_W-1:0]      in_bits_q;
    logic                 in_full_q, io_i_valid_q;
    logic [IO_W-1:0]      fifo_mem_q [OFIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0]    fifo_cnt_q;
    logic [IO_W-1:0]      ser_q;
    logic [OLANE_W-1:0]   ser_lane_q;
    logic                 h_out_valid_q;

    logic start_acc, h_in_xfer, insn_xfer, io_i_xfer, io_o_xfer, h_out_xfer;
    logic ser_last, pop, push, gate_ok, run_complete, last_insn;
    logic [CNT_W-1:0] inflight;
    logic [OCC_W-1:0] occupancy;

    assign start_acc  = (state_q == IDLE) && start;
    assign h_in_xfer  = h_in_valid && h_in_ready;
    assign insn_xfer  = insns_valid_q && insns_ready;
    assign io_i_xfer  = io_i_valid_q && io_i_ready;
    assign io_o_xfer  = io_o_valid && io_o_ready;
    assign h_out_xfer = h_out_valid_q && h_out_ready;
    assign ser_last   = h_out_xfer && (ser_lane_q == OLANE_W'(IO_LANES - 1));
    assign pop        = (!h_out_valid_q || ser_last) && (fifo_cnt_q != '0);
    assign push       = io_o_xfer;
    assign last_insn  = (insn_cnt_q + CNT_W'(1)) == num_insns_q;

    // The vector held by the serializer also counts, so every issued input has a slot to land in.
    assign inflight   = issued_q - received_q;
    assign occupancy  = OCC_W'(inflight) + OCC_W'(fifo_cnt_q) + OCC_W'(h_out_valid_q);
    assign gate_ok    = occupancy < OCC_W'(OFIFO_DEPTH);

    assign run_complete = (issued_q == num_cycles_q) && (received_q == num_cycles_q)
                       && (fifo_cnt_q == '0) && !h_out_valid_q;

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign io_o_ready     = (state_q == RUN);
    assign emu_host_steps = host_steps_q;
    assign emu_used_procs = used_procs_q;
    assign insns_valid    = insns_valid_q;
    assign insns_bits     = insn_bits_q;
    assign io_i_valid     = io_i_valid_q;
    assign io_i_bits      = in_bits_q;
    assign h_out_valid    = h_out_valid_q;
    assign h_out_data     = ser_q[LANE_W-1:0];

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and host input ready
    always_comb begin
        state_d    = state_q;
        h_in_ready = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (cfg_num_insns != '0)       state_d = LOAD;
                else if (cfg_num_cycles != '0) state_d = RUN;
                else                           state_d = DONE;
            end
            LOAD: begin
                h_in_ready = !insns_valid_q;
                if (insn_xfer && last_insn) state_d = (num_cycles_q != '0) ? RUN : DONE;
            end
            RUN: begin
                h_in_ready = !in_full_q && (issued_q != num_cycles_q);
                if (run_complete) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Configuration latch and progress counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            num_insns_q  <= '0;
            num_cycles_q <= '0;
            host_steps_q <= '0;
            used_procs_q <= '0;
            insn_cnt_q   <= '0;
            issued_q     <= '0;
            received_q   <= '0;
        end else if (start_acc) begin
            num_insns_q  <= cfg_num_insns;
            num_cycles_q <= cfg_num_cycles;
            host_steps_q <= cfg_host_steps;
            used_procs_q <= cfg_used_procs;
            insn_cnt_q   <= '0;
            issued_q     <= '0;
            received_q   <= '0;
        end else begin
            if (insn_xfer) insn_cnt_q <= insn_cnt_q + CNT_W'(1);
            if (io_i_xfer) issued_q   <= issued_q + CNT_W'(1);
            if (io_o_xfer) received_q <= received_q + CNT_W'(1);
        end
    end

    // Instruction and input-vector assemblers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            insn_lane_q   <= '0;
            insn_bits_q   <= '0;
            insns_valid_q <= 1'b0;
            in_lane_q     <= '0;
            in_bits_q     <= '0;
            in_full_q     <= 1'b0;
            io_i_valid_q  <= 1'b0;
        end else begin
            if (h_in_xfer && state_q == LOAD) begin
                insn_bits_q[insn_lane_q*LANE_W +: LANE_W] <= h_in_data;
                if (insn_lane_q == ILANE_W'(INSN_LANES - 1)) begin
                    insn_lane_q   <= '0;
                    insns_valid_q <= 1'b1;
                end else begin
                    insn_lane_q <= insn_lane_q + ILANE_W'(1);
                end
            end
            if (insn_xfer) insns_valid_q <= 1'b0;

            if (h_in_xfer && state_q == RUN) begin
                in_bits_q[in_lane_q*LANE_W +: LANE_W] <= h_in_data;
                if (in_lane_q == OLANE_W'(IO_LANES - 1)) begin
                    in_lane_q <= '0;
                    in_full_q <= 1'b1;
                end else begin
                    in_lane_q <= in_lane_q + OLANE_W'(1);
                end
            end
            // A complete vector is offered only once a buffer slot is guaranteed for its result.
            if (in_full_q && !io_i_valid_q && gate_ok) io_i_valid_q <= 1'b1;
            if (io_i_xfer) begin
                io_i_valid_q <= 1'b0;
                in_full_q    <= 1'b0;
            end
        end
    end

    // Output FIFO storage
    always_ff @(posedge clock) begin
        if (push) fifo_mem_q[wr_ptr_q] <= io_o_bits;
    end

    // Output FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + FCNT_W'(1);
            else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - FCNT_W'(1);
        end
    end

    // Serializer: lane 0 is presented first; next vector reloads on the last lane's transfer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ser_q         <= '0;
            ser_lane_q    <= '0;
            h_out_valid_q <= 1'b0;
        end else if (pop) begin
            ser_q         <= fifo_mem_q[rd_ptr_q];
            ser_lane_q    <= '0;
            h_out_valid_q <= 1'b1;
        end else if (h_out_xfer) begin
            ser_q      <= ser_q >> LANE_W;
            ser_lane_q <= ser_lane_q + OLANE_W'(1);
            if (ser_last) h_out_valid_q <= 1'b0;
        end
    end

`ifdef EMU_SEQ_STALL_CNT_EN
    logic [31:0] perf_stall_q;
    logic        stall;

    assign stall      = (io_i_valid_q && !io_i_ready) || (h_out_valid_q && !h_out_ready);
    assign perf_stall = perf_stall_q;

    // Saturating count of stalled RUN cycles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                             perf_stall_q <= '0;
        else if (start_acc)                                       perf_stall_q <= '0;
        else if (state_q == RUN && stall && perf_stall_q != '1)   perf_stall_q <= perf_stall_q + 32'd1;
    end
`endif

endmodule

// File: tb/tb_emu_host_sequencer.sv
// Self-checking bench for emu_host_sequencer with an echoing emulator stub.
module tb_emu_host_sequencer;

    localparam int unsigned LANE_W = 16;
    localparam int unsigned IO_W   = 64;
    localparam int unsigned INSN_W = 32;
    localparam int STEPS = 6;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [15:0]       cfg_num_insns = '0, cfg_num_cycles = '0, cfg_host_steps = '0;
    logic [2:0]        cfg_used_procs = '0;
    logic              start = 1'b0;
    logic              busy, done;
    logic              h_in_valid = 1'b0, h_in_ready;
    logic [15:0]       h_in_data = '0;
    logic              h_out_valid, h_out_ready = 1'b1;
    logic [15:0]       h_out_data;
    logic [15:0]       emu_host_steps;
    logic [2:0]        emu_used_procs;
    logic              insns_valid, insns_ready = 1'b1;
    logic [INSN_W-1:0] insns_bits;
    logic              io_i_valid, io_i_ready = 1'b1;
    logic [IO_W-1:0]   io_i_bits;
    logic              io_o_valid = 1'b0, io_o_ready;
    logic [IO_W-1:0]   io_o_bits = '0;
`ifdef EMU_SEQ_STALL_CNT_EN
    logic [31:0]       perf_stall;
`endif

    emu_host_sequencer dut (
        .clock(clock), .reset_n(reset_n),
        .cfg_num_insns(cfg_num_insns), .cfg_num_cycles(cfg_num_cycles),
        .cfg_host_steps(cfg_host_steps), .cfg_used_procs(cfg_used_procs),
        .start(start), .busy(busy), .done(done),
        .h_in_valid(h_in_valid), .h_in_ready(h_in_ready), .h_in_data(h_in_data),
        .h_out_valid(h_out_valid), .h_out_ready(h_out_ready), .h_out_data(h_out_data),
        .emu_host_steps(emu_host_steps), .emu_used_procs(emu_used_procs),
        .insns_valid(insns_valid), .insns_ready(insns_ready), .insns_bits(insns_bits),
        .io_i_valid(io_i_valid), .io_i_ready(io_i_ready), .io_i_bits(io_i_bits),
        .io_o_valid(io_o_valid), .io_o_ready(io_o_ready), .io_o_bits(io_o_bits)
`ifdef EMU_SEQ_STALL_CNT_EN
        , .perf_stall(perf_stall)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_issued = 0, n_recv = 0, done_cnt = 0;
    logic [15:0] got_out[$];
    logic [15:0] exp_out[$];
    logic [31:0] got_insn[$];
    logic [31:0] exp_insn[$];

    typedef struct { logic [IO_W-1:0] bits; int due; } stub_t;
    stub_t stub_q[$];

    // Monitor: handshakes are sampled mid-cycle, they complete on the following rising edge
    always @(negedge clock) begin
        if (reset_n) begin
            if (io_i_valid && io_i_ready) begin
                stub_q.push_back('{bits: io_i_bits, due: cyc + STEPS});
                n_issued++;
            end
            if (io_o_valid && io_o_ready) begin
                void'(stub_q.pop_front());
                n_recv++;
            end
            if (h_out_valid && h_out_ready) got_out.push_back(h_out_data);
            if (insns_valid && insns_ready) got_insn.push_back(insns_bits);
            if (done) done_cnt++;
        end
    end

    // Emulator stub: echoes each input vector as an output vector STEPS cycles later
    always @(posedge clock) begin
        #1;
        cyc++;
        if (!reset_n) stub_q.delete();
        if (stub_q.size() != 0 && stub_q[0].due <= cyc) begin
            io_o_valid = 1'b1;
            io_o_bits  = stub_q[0].bits;
        end else begin
            io_o_valid = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_start(input int ni, input int nc, input int hs, input int up);
        cfg_num_insns  = 16'(ni);
        cfg_num_cycles = 16'(nc);
        cfg_host_steps = 16'(hs);
        cfg_used_procs = 3'(up);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        h_in_valid = 1'b1;
        h_in_data  = w;
        for (int t = 0; t < 4000; t++) begin
            @(negedge clock);
            if (h_in_ready) begin
                @(posedge clock);
                #1;
                h_in_valid = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL send_word timeout: word %h never accepted", w);
        h_in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        for (int t = 0; t < 3000; t++) begin
            if (done_cnt != d0) begin
                tick(2);
                return;
            end
            tick(1);
        end
        checks++; errors++;
        $display("FAIL %s done timeout: done count %0d, required %0d", name, done_cnt, d0 + 1);
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if ({busy, done, insns_valid, io_i_valid, h_out_valid, h_in_ready, io_o_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_during: ctl %b, required 0", {busy, done, insns_valid, io_i_valid, h_out_valid, h_in_ready, io_o_ready});
        end
        checks++;
        if (emu_host_steps !== 16'h0) begin
            errors++; $display("FAIL reset_during_steps: got %h, required 0", emu_host_steps);
        end
        reset_n = 1'b1;
        tick(2);
        checks++;
        if ({busy, done, insns_valid, io_i_valid, h_out_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_after: ctl %b, required 0", {busy, done, insns_valid, io_i_valid, h_out_valid});
        end
        checks++;
        if (emu_host_steps !== 16'h0) begin
            errors++; $display("FAIL reset_after_steps: got %h, required 0", emu_host_steps);
        end
    endtask

    task automatic test_load();
        logic [15:0] words [6] = '{16'h1, 16'h80, 16'h0, 16'h100, 16'hb33, 16'h184};
        logic [15:0] vec   [4] = '{16'h11, 16'h22, 16'h33, 16'h44};
        int d0 = done_cnt;
        logic [31:0] e;
        got_insn.delete(); got_out.delete();
        exp_insn.push_back(32'h0080_0001);
        exp_insn.push_back(32'h0100_0000);
        exp_insn.push_back(32'h0184_0b33);
        foreach (vec[i]) exp_out.push_back(vec[i]);
        do_start(3, 1, STEPS, 2);
        foreach (words[i]) send_word(words[i]);
        foreach (vec[i]) send_word(vec[i]);
        wait_done(d0, "load");
        checks++;
        if (got_insn.size() != 3) begin
            errors++; $display("FAIL load_count: got %0d insns, required 3", got_insn.size());
        end
        while (exp_insn.size() != 0) begin
            e = exp_insn.pop_front();
            checks++;
            if (got_insn.size() == 0) begin
                errors++; $display("FAIL load_insn: missing, required %h", e);
            end else if (got_insn[0] !== e) begin
                errors++; $display("FAIL load_insn: got %h, required %h", got_insn[0], e);
                void'(got_insn.pop_front());
            end else void'(got_insn.pop_front());
        end
        while (exp_out.size() != 0) begin
            logic [15:0] x = exp_out.pop_front();
            checks++;
            if (got_out.size() == 0 || got_out[0] !== x) begin
                errors++; $display("FAIL load_run_word: got %h, required %h", got_out.size() ? got_out[0] : 16'hxxxx, x);
            end
            if (got_out.size() != 0) void'(got_out.pop_front());
        end
        checks++;
        if (emu_used_procs !== 3'd2) begin
            errors++; $display("FAIL load_procs: got %0d, required 2", emu_used_procs);
        end
    endtask

    task automatic test_run();
        logic [15:0] lane0 [4] = '{16'h0, 16'h4, 16'h9, 16'hf};
        int d0 = done_cnt;
        got_out.delete();
        foreach (lane0[v]) for (int l = 0; l < 4; l++) exp_out.push_back(l == 0 ? lane0[v] : 16'h0);
        do_start(0, 4, STEPS, 5);
        foreach (lane0[v]) for (int l = 0; l < 4; l++) send_word(l == 0 ? lane0[v] : 16'h0);
        wait_done(d0, "run");
        checks++;
        if (got_out.size() != 16) begin
            errors++; $display("FAIL run_count: got %0d words, required 16", got_out.size());
        end
        for (int i = 0; exp_out.size() != 0; i++) begin
            logic [15:0] x = exp_out.pop_front();
            checks++;
            if (got_out.size() == 0 || got_out[0] !== x) begin
                errors++; $display("FAIL run_word %0d: got %h, required %h", i, got_out.size() ? got_out[0] : 16'hxxxx, x);
            end
            if (got_out.size() != 0) void'(got_out.pop_front());
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL run_done_pulses: got %0d, required 1", done_cnt - d0);
        end
        checks++;
        if (emu_host_steps !== 16'(STEPS) || busy !== 1'b0) begin
            errors++; $display("FAIL run_status: steps %0d busy %b, required %0d and 0", emu_host_steps, busy, STEPS);
        end
    endtask

    task automatic send_bp_words(output bit fin);
        for (int k = 0; k < 12; k++)
            for (int l = 0; l < 4; l++) send_word(16'h1000 + 16'(k * 4 + l));
        fin = 1'b1;
    endtask

    task automatic test_backpressure();
        int d0 = done_cnt;
        int i0 = n_issued;
        int r0 = n_recv;
        bit sent = 1'b0;
        got_out.delete();
        for (int k = 0; k < 48; k++) exp_out.push_back(16'h1000 + 16'(k));
        h_out_ready = 1'b0;
        do_start(0, 12, STEPS, 1);
        fork
            send_bp_words(sent);
        join_none
        tick(120);
        checks++;
        if (n_issued - i0 > 8 || n_issued - i0 < 1) begin
            errors++; $display("FAIL bp_issued: got %0d, required 1..8", n_issued - i0);
        end
        checks++;
        if (n_recv - r0 != n_issued - i0) begin
            errors++; $display("FAIL bp_received: got %0d, required %0d", n_recv - r0, n_issued - i0);
        end
        checks++;
        if (got_out.size() != 0) begin
            errors++; $display("FAIL bp_stalled_out: got %0d words, required 0", got_out.size());
        end
        h_out_ready = 1'b1;
        wait_done(d0, "backpressure");
        checks++;
        if (!sent || got_out.size() != 48) begin
            errors++; $display("FAIL bp_count: got %0d words sent %b, required 48 and 1", got_out.size(), sent);
        end
        for (int i = 0; exp_out.size() != 0; i++) begin
            logic [15:0] x = exp_out.pop_front();
            checks++;
            if (got_out.size() == 0 || got_out[0] !== x) begin
                errors++; $display("FAIL bp_word %0d: got %h, required %h", i, got_out.size() ? got_out[0] : 16'hxxxx, x);
            end
            if (got_out.size() != 0) void'(got_out.pop_front());
        end
    endtask

    task automatic test_zero_counts();
        int d0 = done_cnt;
        int i0 = n_issued;
        got_out.delete(); got_insn.delete();
        h_in_valid = 1'b1;
        h_in_data  = 16'hdead;
        do_start(0, 0, 3, 0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || h_in_ready !== 1'b0) begin
            errors++; $display("FAIL zero_done_edge2: done %b busy %b ready %b, required 1 1 0", done, busy, h_in_ready);
        end
        tick(1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_idle: done %b busy %b, required 0 0", done, busy);
        end
        h_in_valid = 1'b0;
        tick(2);
        checks++;
        if (done_cnt - d0 != 1 || n_issued != i0 || got_out.size() != 0 || got_insn.size() != 0) begin
            errors++; $display("FAIL zero_activity: pulses %0d issued %0d out %0d insns %0d, required 1 0 0 0",
                               done_cnt - d0, n_issued - i0, got_out.size(), got_insn.size());
        end
    endtask

    task automatic test_abort();
        int d0;
        got_out.delete();
        do_start(0, 3, STEPS, 4);
        for (int l = 0; l < 4; l++) send_word(16'h2000 + 16'(l));
        tick(3);
        reset_n = 1'b0;
        tick(2);
        checks++;
        if ({busy, done, io_i_valid, h_out_valid, h_in_ready} !== 5'b0 || emu_host_steps !== 16'h0) begin
            errors++; $display("FAIL abort_reset: ctl %b steps %h, required 0 0", {busy, done, io_i_valid, h_out_valid, h_in_ready}, emu_host_steps);
        end
        reset_n = 1'b1;
        tick(2);
        got_out.delete();
        d0 = done_cnt;
        for (int l = 0; l < 4; l++) exp_out.push_back(16'h3000 + 16'(l));
        do_start(0, 1, STEPS, 4);
        for (int l = 0; l < 4; l++) send_word(16'h3000 + 16'(l));
        wait_done(d0, "abort");
        tick(10);
        checks++;
        if (got_out.size() != 4) begin
            errors++; $display("FAIL abort_count: got %0d words, required 4", got_out.size());
        end
        for (int i = 0; exp_out.size() != 0; i++) begin
            logic [15:0] x = exp_out.pop_front();
            checks++;
            if (got_out.size() == 0 || got_out[0] !== x) begin
                errors++; $display("FAIL abort_word %0d: got %h, required %h", i, got_out.size() ? got_out[0] : 16'hxxxx, x);
            end
            if (got_out.size() != 0) void'(got_out.pop_front());
        end
    endtask

`ifdef EMU_SEQ_STALL_CNT_EN
    task automatic test_stall_counter();
        int d0 = done_cnt;
        int t = 0;
        io_i_ready = 1'b0;
        do_start(0, 1, STEPS, 1);
        for (int l = 0; l < 4; l++) send_word(16'h4000 + 16'(l));
        while (!io_i_valid && t < 100) begin tick(1); t++; end
        tick(5);
        io_i_ready = 1'b1;
        wait_done(d0, "stall");
        tick(3);
        checks++;
        if (perf_stall !== 32'd5) begin
            errors++; $display("FAIL stall_count: got %0d, required 5", perf_stall);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_run();
        test_backpressure();
        test_zero_counts();
        test_abort();
`ifdef EMU_SEQ_STALL_CNT_EN
        test_stall_counter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
